// File: rtl/cc_miss_req_scheduler_if.sv
// Miss request / AXI AR / line-fill bus bundle.
// slave: scheduler side, master: cache and memory side.
interface cc_miss_req_scheduler_if;
  logic        miss_req_valid_i;
  logic [31:0] miss_req_addr_i;
  logic        miss_req_ready_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic [2:0]  outstanding_o;
  logic        underflow_err_o;

  modport slave (
    input  miss_req_valid_i, miss_req_addr_i,
    input  mem_arready_i,
    input  mem_rvalid_i, mem_rready_i, mem_rlast_i,
    input  miss_addr_fifo_full_i,
    output miss_req_ready_o,
    output mem_arvalid_o, mem_araddr_o,
    output mem_arlen_o, mem_arsize_o, mem_arburst_o,
    output miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
    output outstanding_o, underflow_err_o
  );

  modport master (
    output miss_req_valid_i, miss_req_addr_i,
    output mem_arready_i,
    output mem_rvalid_i, mem_rready_i, mem_rlast_i,
    output miss_addr_fifo_full_i,
    input  miss_req_ready_o,
    input  mem_arvalid_o, mem_araddr_o,
    input  mem_arlen_o, mem_arsize_o, mem_arburst_o,
    input  miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
    input  outstanding_o, underflow_err_o
  );
endinterface

// File: rtl/cc_miss_req_scheduler.sv
// Cache miss scheduler: one AR wrap burst per miss,
// credit-limited line fills tracked via R last beats.
module cc_miss_req_scheduler #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                     clk,
  input logic                     rst,
  cc_miss_req_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] araddr;
  logic [2:0]  cnt;
  logic        err;
  logic        accept;
  logic        done;
  logic [31:0] line_addr;

  assign line_addr = {bus.miss_req_addr_i[31:3], 3'b000};
  assign done = bus.mem_rvalid_i & bus.mem_rready_i
              & bus.mem_rlast_i;

  // Acceptance and next state; credit uses the registered count only
  always_comb begin
    accept    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        accept = ~rst & bus.miss_req_valid_i
               & ~bus.miss_addr_fifo_full_i
               & (cnt < MAX_CNT);
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bus.mem_arready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // AR address captured at accept, held through backpressure
  always_ff @(posedge clk) begin
    if (rst)         araddr <= '0;
    else if (accept) araddr <= line_addr;
  end

  // Fill credit counter and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case ({accept, done})
        2'b10: cnt <= cnt + 3'd1;
        2'b01: begin
          if (cnt == 3'd0) err <= 1'b1;
          else             cnt <= cnt - 3'd1;
        end
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.miss_req_ready_o       = accept;
  assign bus.miss_addr_fifo_wren_o  = accept;
  assign bus.miss_addr_fifo_wdata_o = line_addr;
  assign bus.mem_arvalid_o          = (state == ISSUE);
  assign bus.mem_araddr_o           = araddr;
  assign bus.mem_arlen_o            = 4'd7;
  assign bus.mem_arsize_o           = 3'd3;
  assign bus.mem_arburst_o          = 2'b10;
  assign bus.outstanding_o          = cnt;
  assign bus.underflow_err_o        = err;

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// Scoreboard bench for cc_miss_req_scheduler.
// Directed stimulus; monitor checks FIFO writes and AR handshakes.
module tb_cc_miss_req_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] exp_wd[$];
  logic [31:0] exp_ar[$];

  cc_miss_req_scheduler_if bus ();

  cc_miss_req_scheduler #(.MAX_OUTSTANDING(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: FIFO writes and AR handshakes against the scoreboard
  always @(negedge clk) begin
    if (bus.miss_addr_fifo_wren_o === 1'b1) begin
      check("wren_vs_full", {31'd0, bus.miss_addr_fifo_full_i}, 32'd0);
      if (exp_wd.size() == 0) begin
        check("unexpected_wren", 32'd1, 32'd0);
      end else begin
        check("fifo_wdata", bus.miss_addr_fifo_wdata_o,
              exp_wd.pop_front());
      end
    end
    if (bus.mem_arvalid_o === 1'b1 && bus.mem_arready_i === 1'b1) begin
      if (exp_ar.size() == 0) begin
        check("unexpected_ar", 32'd1, 32'd0);
      end else begin
        check("araddr", bus.mem_araddr_o, exp_ar.pop_front());
      end
      check("arlen", {28'd0, bus.mem_arlen_o}, 32'd7);
      check("arsize", {29'd0, bus.mem_arsize_o}, 32'd3);
      check("arburst", {30'd0, bus.mem_arburst_o}, 32'd2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] line(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

  // Present a request until accepted; returns accept cycle
  task automatic send(input logic [31:0] a, input bit push_ar,
                      output int acc);
    int waited;
    waited = 0;
    bus.miss_req_valid_i = 1'b1;
    bus.miss_req_addr_i  = a;
    exp_wd.push_back(line(a));
    if (push_ar) exp_ar.push_back(line(a));
    forever begin
      @(negedge clk);
      if (bus.miss_req_ready_o === 1'b1) break;
      waited++;
      if (waited > 20) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    acc = cyc;
    tick();
    bus.miss_req_valid_i = 1'b0;
  endtask

  task automatic r_beat(input bit last);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rready_i = 1'b1;
    bus.mem_rlast_i  = last;
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rready_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) r_beat(1'b1);
  endtask

  initial begin
    int a0, a1, a2, a3;
    logic [31:0] hold;

    bus.miss_req_valid_i      = 1'b1;
    bus.miss_req_addr_i       = 32'h0000_0040;
    bus.mem_arready_i         = 1'b1;
    bus.mem_rvalid_i          = 1'b0;
    bus.mem_rready_i          = 1'b0;
    bus.mem_rlast_i           = 1'b0;
    bus.miss_addr_fifo_full_i = 1'b0;

    // Reset: no acceptance while rst is high
    tick();
    @(negedge clk);
    check("rst_ready", {31'd0, bus.miss_req_ready_o}, 32'd0);
    check("rst_wren", {31'd0, bus.miss_addr_fifo_wren_o}, 32'd0);
    tick();
    bus.miss_req_valid_i = 1'b0;
    rst = 1'b0;
    check("rst_outstanding", {29'd0, bus.outstanding_o}, 32'd0);
    check("rst_err", {31'd0, bus.underflow_err_o}, 32'd0);
    check("rst_arvalid", {31'd0, bus.mem_arvalid_o}, 32'd0);
    check("rst_araddr", bus.mem_araddr_o, 32'd0);

    // Single miss
    send(32'h0000_1234, 1'b1, a0);
    check("single_arvalid", {31'd0, bus.mem_arvalid_o}, 32'd1);
    check("single_araddr", bus.mem_araddr_o, 32'h0000_1230);
    check("single_out", {29'd0, bus.outstanding_o}, 32'd1);
    tick();
    check("single_idle", {31'd0, bus.mem_arvalid_o}, 32'd0);
    r_beat(1'b0);
    check("nonlast_beat", {29'd0, bus.outstanding_o}, 32'd1);
    r_beat(1'b1);
    check("single_done", {29'd0, bus.outstanding_o}, 32'd0);

    // Credit limit: four back-to-back, fifth stalls
    send(32'h1000_0000, 1'b1, a0);
    send(32'h1000_0104, 1'b1, a1);
    send(32'h1000_020F, 1'b1, a2);
    send(32'h1000_0311, 1'b1, a3);
    check("spacing_1", a1 - a0, 32'd2);
    check("spacing_2", a2 - a0, 32'd4);
    check("spacing_3", a3 - a0, 32'd6);
    bus.miss_req_valid_i = 1'b1;
    bus.miss_req_addr_i  = 32'h1000_0400;
    exp_wd.push_back(32'h1000_0400);
    exp_ar.push_back(32'h1000_0400);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("credit_stall", {31'd0, bus.miss_req_ready_o}, 32'd0);
      tick();
    end
    check("credit_out4", {29'd0, bus.outstanding_o}, 32'd4);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rready_i = 1'b1;
    bus.mem_rlast_i  = 1'b1;
    @(negedge clk);
    check("credit_samecyc", {31'd0, bus.miss_req_ready_o}, 32'd0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rready_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;
    @(negedge clk);
    check("credit_freed", {31'd0, bus.miss_req_ready_o}, 32'd1);
    tick();
    bus.miss_req_valid_i = 1'b0;
    tick();
    check("credit_out_back4", {29'd0, bus.outstanding_o}, 32'd4);
    drain(4);
    check("credit_drained", {29'd0, bus.outstanding_o}, 32'd0);

    // AR backpressure
    bus.mem_arready_i = 1'b0;
    send(32'hDEAD_BEEF, 1'b1, a0);
    bus.miss_req_valid_i = 1'b1;
    bus.miss_req_addr_i  = 32'h5555_0000;
    hold = bus.mem_araddr_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_arvalid", {31'd0, bus.mem_arvalid_o}, 32'd1);
      check("bp_araddr", bus.mem_araddr_o, hold);
      check("bp_ready", {31'd0, bus.miss_req_ready_o}, 32'd0);
      tick();
    end
    bus.mem_arready_i = 1'b1;
    tick();
    bus.miss_req_valid_i = 1'b0;
    check("bp_idle", {31'd0, bus.mem_arvalid_o}, 32'd0);
    check("bp_hold_addr", hold, 32'hDEAD_BEE8);
    drain(1);

    // FIFO full blocks acceptance
    bus.miss_addr_fifo_full_i = 1'b1;
    bus.miss_req_valid_i      = 1'b1;
    bus.miss_req_addr_i       = 32'h0000_ABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready", {31'd0, bus.miss_req_ready_o}, 32'd0);
      check("full_arvalid", {31'd0, bus.mem_arvalid_o}, 32'd0);
      tick();
    end
    bus.miss_addr_fifo_full_i = 1'b0;
    exp_wd.push_back(32'h0000_ABC8);
    exp_ar.push_back(32'h0000_ABC8);
    @(negedge clk);
    check("full_release", {31'd0, bus.miss_req_ready_o}, 32'd1);
    tick();
    bus.miss_req_valid_i = 1'b0;
    tick();
    drain(1);

    // Simultaneous accept and completion at 2
    send(32'h2000_0010, 1'b1, a0);
    send(32'h2000_0020, 1'b1, a0);
    check("sim_out2", {29'd0, bus.outstanding_o}, 32'd2);
    tick();
    exp_wd.push_back(32'h2000_0030);
    exp_ar.push_back(32'h2000_0030);
    bus.miss_req_valid_i = 1'b1;
    bus.miss_req_addr_i  = 32'h2000_0033;
    bus.mem_rvalid_i     = 1'b1;
    bus.mem_rready_i     = 1'b1;
    bus.mem_rlast_i      = 1'b1;
    @(negedge clk);
    check("sim_ready", {31'd0, bus.miss_req_ready_o}, 32'd1);
    tick();
    bus.miss_req_valid_i = 1'b0;
    bus.mem_rvalid_i     = 1'b0;
    bus.mem_rready_i     = 1'b0;
    bus.mem_rlast_i      = 1'b0;
    check("sim_out_still2", {29'd0, bus.outstanding_o}, 32'd2);
    drain(2);
    check("sim_drained", {29'd0, bus.outstanding_o}, 32'd0);
    check("no_err_yet", {31'd0, bus.underflow_err_o}, 32'd0);

    // Underflow: completion at zero is sticky
    r_beat(1'b1);
    check("uf_out", {29'd0, bus.outstanding_o}, 32'd0);
    check("uf_err", {31'd0, bus.underflow_err_o}, 32'd1);
    tick();
    tick();
    check("uf_sticky", {31'd0, bus.underflow_err_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("uf_cleared", {31'd0, bus.underflow_err_o}, 32'd0);

    // Reset while in ISSUE
    bus.mem_arready_i = 1'b0;
    send(32'h4444_4444, 1'b0, a0);
    check("ri_arvalid", {31'd0, bus.mem_arvalid_o}, 32'd1);
    check("ri_out1", {29'd0, bus.outstanding_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ri_arvalid_drop", {31'd0, bus.mem_arvalid_o}, 32'd0);
    check("ri_out0", {29'd0, bus.outstanding_o}, 32'd0);
    exp_wd.push_back(32'h7777_0008);
    exp_ar.push_back(32'h7777_0008);
    bus.miss_req_valid_i = 1'b1;
    bus.miss_req_addr_i  = 32'h7777_000C;
    bus.mem_arready_i    = 1'b1;
    @(negedge clk);
    check("ri_accept", {31'd0, bus.miss_req_ready_o}, 32'd1);
    tick();
    bus.miss_req_valid_i = 1'b0;
    tick();
    check("ri_out_new", {29'd0, bus.outstanding_o}, 32'd1);
    drain(1);
    check("final_out", {29'd0, bus.outstanding_o}, 32'd0);

    check("wd_queue_empty", exp_wd.size(), 32'd0);
    check("ar_queue_empty", exp_ar.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
